// File: rtl/step_gen_pkg.sv
// Shared types and constants for the linear-ramp step generator.
// State encoding is visible on the state port.
package step_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL1 = 3'd1,
    S_DIV  = 3'd2,
    S_VEL  = 3'd3,
    S_MUL2 = 3'd4,
    S_POS  = 3'd5,
    S_DONE = 3'd6
  } state_e;

  // Edges from the accepting edge to the edge that raises out_valid.
  function automatic int latency(input int vw, input int tw);
    return 3 * tw + vw + 2;
  endfunction

endpackage

// File: rtl/step_gen_serial_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// The start edge performs the first iteration; done pulses after NW.
module step_gen_serial_div #(
  parameter int NW = 32,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [NW-1:0] quotient,
  output logic          done
);

  localparam int CW = $clog2(NW);

  logic [NW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [NW-1:0] src;
  logic [DW-1:0] rsrc;
  logic [DW:0]   rsh;
  logic          ge;

  always_comb begin
    src    = start ? dividend : dvd_q;
    rsrc   = start ? '0 : rem_q;
    rsh    = {rsrc, src[NW-1]};
    ge     = rsh >= {1'b0, divisor};
    dvd_d  = dvd_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start || busy_q) begin
      dvd_d = {src[NW-2:0], ge};
      rem_d = ge ? DW'(rsh - {1'b0, divisor}) : DW'(rsh);
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = CW'(1);
      end else if (cnt_q == CW'(NW - 1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient = dvd_q;
  assign done     = done_q;

endmodule

// File: rtl/step_gen_ramp.sv
// Linear-ramp step generator: v(t) and p(t) from one segment request.
// One serial multiplier serves both MUL phases; fixed latency.
module step_gen_ramp
  import step_gen_pkg::*;
#(
  parameter int VW = 16,
  parameter int TW = 16,
  parameter int PW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          in_ready,
  input  logic [VW-1:0] in_start_velocity,
  input  logic [VW-1:0] in_end_velocity,
  input  logic [TW-1:0] in_cur_time,
  input  logic [TW-1:0] in_time_interval,
  input  logic [PW-1:0] in_start_step_pos,
  input  logic          in_dir,
  output logic [2:0]    state,
  output logic          out_valid,
  output logic [VW-1:0] out_cur_velocity,
  output logic [PW-1:0] out_cur_step_pos,
  output logic          out_err
);

  localparam int NW = VW + TW;
  localparam int AW = VW + TW + 1;
  localparam int CW = $clog2(NW);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [VW-1:0] v0_q, v0_d;
  logic signed [VW-1:0] v1_q, v1_d;
  logic signed [VW-1:0] v_q, v_d;
  logic signed [VW:0]   dv_q, dv_d;
  logic [TW-1:0]        tc_q, tc_d;
  logic [TW-1:0]        per_q, per_d;
  logic [TW-1:0]        mpl_q, mpl_d;
  logic signed [PW-1:0] p0_q, p0_d;
  logic                 dir_q, dir_d;
  logic                 zf_q, zf_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [VW-1:0] ovel_q, ovel_d;
  logic signed [PW-1:0] opos_q, opos_d;
  logic                 oerr_q, oerr_d;
  logic                 oval_q, oval_d;

  logic signed [VW:0]   vsum, mcand, qs;
  logic signed [AW-1:0] mext, off_full;
  logic signed [PW-1:0] off_p;
  logic [VW:0]          qmag;
  logic [NW-1:0]        dvd, quo;
  logic                 div_start, div_done;

  always_comb begin
    vsum      = (VW+1)'(v0_q) + (VW+1)'(v_q);
    mcand     = (state_q == S_MUL2) ? vsum : dv_q;
    mext      = AW'(mcand);
    off_full  = acc_q >>> 1;
    off_p     = PW'(off_full);
    qmag      = (VW+1)'(quo);
    qs        = acc_q[AW-1] ? -$signed(qmag) : $signed(qmag);
    dvd       = acc_q[AW-1] ? NW'(-acc_q) : NW'(acc_q);
    div_start = (state_q == S_DIV) && (cnt_q == '0) && !zf_q;
  end

  // With T==0 the divider is never started, so done stays low.
  step_gen_serial_div #(
    .NW(NW),
    .DW(TW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (dvd),
    .divisor  (per_q),
    .quotient (quo),
    .done     (div_done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    v_d     = v_q;
    dv_d    = dv_q;
    tc_d    = tc_q;
    per_d   = per_q;
    mpl_d   = mpl_q;
    p0_d    = p0_q;
    dir_d   = dir_q;
    zf_d    = zf_q;
    acc_d   = acc_q;
    ovel_d  = ovel_q;
    opos_d  = opos_q;
    oerr_d  = oerr_q;
    oval_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          v0_d  = $signed(in_start_velocity);
          v1_d  = $signed(in_end_velocity);
          dv_d  = (VW+1)'($signed(in_end_velocity))
                - (VW+1)'($signed(in_start_velocity));
          tc_d  = (in_cur_time < in_time_interval)
                ? in_cur_time : in_time_interval;
          per_d = in_time_interval;
          p0_d  = $signed(in_start_step_pos);
          dir_d = in_dir;
          zf_d  = (in_time_interval == '0);
          mpl_d = (in_cur_time < in_time_interval)
                ? in_cur_time : in_time_interval;
          acc_d = '0;
          cnt_d = '0;
          state_d = S_MUL1;
        end
      end
      S_MUL1, S_MUL2: begin
        acc_d = (acc_q <<< 1) + (mpl_q[TW-1] ? mext : '0);
        mpl_d = mpl_q << 1;
        if (cnt_q == CW'(TW - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == S_MUL1) ? S_DIV : S_POS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DIV: begin
        if (cnt_q == CW'(NW - 1)) begin
          cnt_d   = '0;
          state_d = S_VEL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VEL: begin
        v_d     = div_done ? VW'(v0_q + qs) : v1_q;
        acc_d   = '0;
        mpl_d   = tc_q;
        state_d = S_MUL2;
      end
      S_POS: begin
        ovel_d  = v_q;
        opos_d  = zf_q ? p0_q
                : (dir_q ? p0_q - off_p : p0_q + off_p);
        oerr_d  = zf_q;
        oval_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
      v_q     <= '0;
      dv_q    <= '0;
      tc_q    <= '0;
      per_q   <= '0;
      mpl_q   <= '0;
      p0_q    <= '0;
      dir_q   <= 1'b0;
      zf_q    <= 1'b0;
      acc_q   <= '0;
      ovel_q  <= '0;
      opos_q  <= '0;
      oerr_q  <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v_q     <= v_d;
      dv_q    <= dv_d;
      tc_q    <= tc_d;
      per_q   <= per_d;
      mpl_q   <= mpl_d;
      p0_q    <= p0_d;
      dir_q   <= dir_d;
      zf_q    <= zf_d;
      acc_q   <= acc_d;
      ovel_q  <= ovel_d;
      opos_q  <= opos_d;
      oerr_q  <= oerr_d;
      oval_q  <= oval_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign state            = state_q;
  assign out_valid        = oval_q;
  assign out_cur_velocity = ovel_q;
  assign out_cur_step_pos = opos_q;
  assign out_err          = oerr_q;

endmodule

// File: tb/tb_step_gen_ramp.sv
// Bench for step_gen_ramp: directed requests, queued expectations,
// and a monitor that checks each out_valid pulse.
module tb_step_gen_ramp;
  import step_gen_pkg::*;

  localparam int VW = 16;
  localparam int TW = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_start_velocity = '0;
  logic [VW-1:0] in_end_velocity = '0;
  logic [TW-1:0] in_cur_time = '0;
  logic [TW-1:0] in_time_interval = '0;
  logic [PW-1:0] in_start_step_pos = '0;
  logic          in_dir = 1'b0;
  logic [2:0]    state;
  logic          out_valid;
  logic [VW-1:0] out_cur_velocity;
  logic [PW-1:0] out_cur_step_pos;
  logic          out_err;

  typedef struct {
    int            id;
    logic [VW-1:0] vel;
    logic [PW-1:0] pos;
    logic          err;
    int            acc;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic prev_valid = 1'b0;

  step_gen_ramp #(.VW(VW), .TW(TW), .PW(PW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .in_ready          (in_ready),
    .in_start_velocity (in_start_velocity),
    .in_end_velocity   (in_end_velocity),
    .in_cur_time       (in_cur_time),
    .in_time_interval  (in_time_interval),
    .in_start_step_pos (in_start_step_pos),
    .in_dir            (in_dir),
    .state             (state),
    .out_valid         (out_valid),
    .out_cur_velocity  (out_cur_velocity),
    .out_cur_step_pos  (out_cur_step_pos),
    .out_err           (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_valid)
        chk("valid_pulse_width", 64'(out_valid), 64'd0);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got out_valid=1, required 0");
        end else begin
          e = sbq.pop_front();
          chk($sformatf("t%0d_vel", e.id), 64'(out_cur_velocity),
              64'(e.vel));
          chk($sformatf("t%0d_pos", e.id), 64'(out_cur_step_pos),
              64'(e.pos));
          chk($sformatf("t%0d_err", e.id), 64'(out_err), 64'(e.err));
          chk($sformatf("t%0d_latency", e.id), 64'(cyc - e.acc),
              64'(latency(VW, TW)));
        end
      end
    end
    prev_valid = out_valid;
  end

  task automatic issue(input int id,
                       input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                       input logic [TW-1:0] t, input logic [TW-1:0] tt,
                       input logic [PW-1:0] p0, input logic dir,
                       input logic [VW-1:0] ev, input logic [PW-1:0] ep,
                       input logic eerr);
    exp_t e;
    int   k;
    k = 0;
    while (!in_ready && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk($sformatf("t%0d_ready_wait", id), 64'(in_ready), 64'd1);
    in_start_velocity = v0;
    in_end_velocity   = v1;
    in_cur_time       = t;
    in_time_interval  = tt;
    in_start_step_pos = p0;
    in_dir            = dir;
    start             = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.id  = id;
    e.vel = ev;
    e.pos = ep;
    e.err = eerr;
    e.acc = cyc;
    sbq.push_back(e);
  endtask

  initial begin
    int busy_hi;
    int k;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_vel", 64'(out_cur_velocity), 64'd0);
    chk("rst_pos", 64'(out_cur_step_pos), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1, 16'd100, 16'd300, 16'd500, 16'd1000, 32'd1000, 1'b0,
          16'd200, 32'd76000, 1'b0);

    issue(2, 16'd100, 16'd300, 16'd500, 16'd1000, 32'd1000, 1'b1,
          16'd200, -32'sd74000, 1'b0);
    busy_hi = 0;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) busy_hi++;
      if (i == 20) begin
        in_end_velocity   = -16'sd1000;
        in_start_step_pos = 32'd7;
        in_dir            = 1'b0;
        start             = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("t2_ready_low_busy", 64'(busy_hi), 64'd0);

    issue(3, 16'd300, 16'd100, 16'd250, 16'd1000, 32'd0, 1'b0,
          16'd250, 32'd68750, 1'b0);
    issue(4, 16'd0, -16'sd7, 16'd1, 16'd2, 32'd0, 1'b0,
          -16'sd3, -32'sd2, 1'b0);
    issue(5, 16'd50, 16'd150, 16'd2000, 16'd1000, 32'd0, 1'b0,
          16'd150, 32'd100000, 1'b0);
    issue(6, 16'd10, 16'd77, 16'd40, 16'd0, 32'd5, 1'b0,
          16'd77, 32'd5, 1'b1);
    issue(7, 16'd100, 16'd100, 16'd1, 16'd1, 32'h7FFF_FFF0, 1'b0,
          16'd100, 32'h8000_0054, 1'b0);
    issue(8, 16'h8000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 32'd0, 1'b0,
          16'h7FFF, -32'sd32768, 1'b0);
    issue(9, -16'sd100, -16'sd300, 16'd500, 16'd1000, 32'd0, 1'b1,
          -16'sd200, 32'd75000, 1'b0);

    issue(10, 16'd100, 16'd300, 16'd500, 16'd1000, 32'd1000, 1'b0,
          16'd200, 32'd76000, 1'b0);
    repeat (29) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_vel", 64'(out_cur_velocity), 64'd0);
    chk("midrst_pos", 64'(out_cur_step_pos), 64'd0);
    chk("midrst_err", 64'(out_err), 64'd0);
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(11, 16'd100, 16'd300, 16'd500, 16'd1000, 32'd1000, 1'b0,
          16'd200, 32'd76000, 1'b0);

    k = 0;
    while (sbq.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/step_gen_ramp.md
Name: step_gen_ramp

Overview:
Parametrised next-generation linear-ramp step generator. Per request it computes the instantaneous velocity v(t) = v0 + (v1-v0)*t/T and the integrated step position p(t) = p0 ± (v0+v(t))*t/2. It uses a shared serial shift-add multiplier and a restoring divider instead of external mul/div blocks. It sits between the motion planner, which issues segment requests, and the step/dir pulse stage, which consumes the velocity and position results.

Parameters:
VW, 16, velocity width (signed two's complement)
TW, 16, time width (unsigned)
PW, 32, step position width (signed)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request strobe; accepted only when in_ready=1
in_ready  out  1  high in IDLE
in_start_velocity  in  VW  v0, signed
in_end_velocity  in  VW  v1, signed
in_cur_time  in  TW  t, unsigned
in_time_interval  in  TW  T, unsigned
in_start_step_pos  in  PW  p0, signed
in_dir  in  1  0: p0 + offset, 1: p0 - offset
state  out  3  FSM state, encoded per package
out_valid  out  1  one-cycle pulse when results update
out_cur_velocity  out  VW  v(t), signed, held until next out_valid
out_cur_step_pos  out  PW  p(t), signed, held until next out_valid
out_err  out  1  T==0 on the last request; held with the results

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, out_cur_velocity=0, out_cur_step_pos=0, out_err=0. All internal registers are cleared. Reset mid-operation aborts the request; no out_valid is produced.
- Accept: on a rising edge with state=IDLE and start=1, latch all inputs. Latch tc = min(t, T), dv = v1-v0 (VW+1 bits), and the zero flag zf = (T==0). Go to MUL1.
- start is ignored in any state other than IDLE. No queuing.
- MUL1 (TW cycles): serial product m = dv*tc, 1 bit of tc per cycle, signed result VW+TW+1 bits.
- DIV (VW+TW cycles): restoring divide of |m| by T. Quotient takes the sign of m and truncates toward zero. Since tc<=T, |q|<=|dv|.
- VEL (1 cycle): v = v0 + q. This cannot overflow VW bits because v lies between v0 and v1. If zf=1, v = v1.
- MUL2 (TW cycles): s = (v0+v)*tc, VW+1 by TW bits, signed.
- POS (1 cycle): off = s >>> 1 (arithmetic, rounds toward -inf). The offset is sign-extended or truncated to PW bits and p = p0 + off (in_dir=0) or p0 - off (in_dir=1), wrapping modulo 2^PW. If zf=1, p = p0. This cycle registers out_cur_velocity, out_cur_step_pos, out_err=zf, sets out_valid=1, and goes to DONE.
- DONE (1 cycle): out_valid=0, then IDLE.
- Latency: the edge that sets out_valid is exactly 3*TW+VW+2 edges after the accepting edge (66 for the defaults). Throughput is one request per 3*TW+VW+4 cycles.
- With zf=1 the FSM still walks every state, so latency is fixed. The divider is bypassed and its result discarded.
- Multiplier and divider iteration counters run 0..N-1, then reset to 0 on state exit.

Decomposition:
- step_gen_pkg: state encodings IDLE=0, MUL1=1, DIV=2, VEL=3, MUL2=4, POS=5, DONE=6, plus the latency formula as a constant function.
- Sub-module step_gen_serial_div, parametrised by width. It has start/done handshake, unsigned restoring division, and a fixed N-cycle latency. The multiplier stays inline because it is shared by MUL1 and MUL2.

Test Plan:
- v0=100, v1=300, T=1000, t=500, p0=1000, dir=0 -> after 66 cycles out_valid pulses once; velocity=200, pos=76000, err=0.
- Same request with dir=1 -> velocity=200, pos=-74000; in_ready=0 throughout, and a start pulse mid-operation is ignored.
- Deceleration v0=300, v1=100, T=1000, t=250, p0=0 -> velocity=250, pos=68750. Negative rounding case v0=0, v1=-7, T=2, t=1 -> velocity=-3, pos=-2.
- Clamp v0=50, v1=150, T=1000, t=2000, p0=0 -> velocity=150, pos=100000. T=0, v1=77, p0=5 -> velocity=77, pos=5, err=1, latency still 66.
- Wrap: p0=0x7FFFFFF0, v0=v1=100, T=t=1 -> pos=0x80000054. Reset asserted at cycle 30 of a request -> outputs immediately 0, no out_valid, and the next request completes normally.
